// File: rtl/ov7670_emulador_pkg.sv
// Shared constants for the OV7670 transmitter emulator: default frame geometry,
// state encodings, debug codes and counter-width helpers.
package ov7670_emulador_pkg;

    localparam int COLUNAS_PADRAO   = 8;
    localparam int LINHAS_PADRAO    = 4;
    localparam int VSYNC_LEN_PADRAO = 3;
    localparam int BLANK_V_PADRAO   = 2;
    localparam int BLANK_H_PADRAO   = 4;
    localparam int PCLK_DIV_PADRAO  = 2;

    localparam logic [2:0] EST_INICIAL = 3'd0;
    localparam logic [2:0] EST_VSYNC   = 3'd1;
    localparam logic [2:0] EST_BLANK_V = 3'd2;
    localparam logic [2:0] EST_LINHA   = 3'd3;
    localparam logic [2:0] EST_BLANK_H = 3'd4;

    localparam logic [3:0] DB_ILEGAL = 4'b1110;

    function automatic int largura(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int maximo(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ov7670_emulador_if.sv
// Parallel camera bus between the emulated sensor (master) and the capture side.
interface ov7670_emulador_if;
    logic       PCLK;
    logic       VSYNC;
    logic       HREF;
    logic [7:0] D;
    logic       PWDN;

    modport master (output PCLK, output VSYNC, output HREF, output D, input PWDN);
    modport slave  (input PCLK, input VSYNC, input HREF, input D, output PWDN);
endinterface

// File: rtl/ov7670_emulador_gerador_pclk.sv
// PCLK divider: counts 0..2*PCLK_DIV-1; tick marks the wrap (PCLK falling edge).
// Dropping habilitar clears the divider and holds PCLK low.
module ov7670_emulador_gerador_pclk
    import ov7670_emulador_pkg::*;
#(
    parameter int PCLK_DIV = PCLK_DIV_PADRAO
) (
    input  logic clock,
    input  logic reset,
    input  logic habilitar,
    output logic pclk,
    output logic tick
);
    localparam int PERIODO = 2 * PCLK_DIV;
    localparam int DW      = largura(PERIODO);

    logic [DW-1:0] div_r;
    logic [DW-1:0] div_prox_s;
    logic          pclk_r;

    // next divider value and wrap detection
    always_comb begin
        div_prox_s = {DW{1'b0}};
        tick       = 1'b0;
        if (!habilitar) begin
            div_prox_s = {DW{1'b0}};
        end else if (div_r == DW'(PERIODO - 1)) begin
            tick       = 1'b1;
            div_prox_s = {DW{1'b0}};
        end else begin
            div_prox_s = div_r + DW'(1);
        end
    end

    // divider and registered PCLK
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_r  <= {DW{1'b0}};
            pclk_r <= 1'b0;
        end else begin
            div_r  <= div_prox_s;
            pclk_r <= habilitar && (div_prox_s >= DW'(PCLK_DIV));
        end
    end

    assign pclk = pclk_r;
endmodule

// File: rtl/ov7670_emulador.sv
// OV7670 transmitter emulator: VSYNC/HREF/PCLK timing and a frame-linear byte
// count on D, so the capture path can be exercised without a sensor.
module ov7670_emulador
    import ov7670_emulador_pkg::*;
#(
    parameter int COLUNAS   = COLUNAS_PADRAO,
    parameter int LINHAS    = LINHAS_PADRAO,
    parameter int VSYNC_LEN = VSYNC_LEN_PADRAO,
    parameter int BLANK_V   = BLANK_V_PADRAO,
    parameter int BLANK_H   = BLANK_H_PADRAO,
    parameter int PCLK_DIV  = PCLK_DIV_PADRAO
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    iniciar,
    input  logic                    continuo,
    ov7670_emulador_if.master       cam,
    output logic                    fim_frame,
    output logic [3:0]              db_estado
);
    localparam int MAIOR = maximo(maximo(VSYNC_LEN, BLANK_V), maximo(COLUNAS, BLANK_H));
    localparam int TW    = largura(MAIOR);
    localparam int LW    = largura(LINHAS);

    logic [2:0]    estado_r, estado_prox_s;
    logic [TW-1:0] cont_r, cont_prox_s;
    logic [LW-1:0] linha_r, linha_prox_s;
    logic [7:0]    byte_r, byte_prox_s;
    logic          fim_s, ilegal_s, habilitar_s, tick_s, pclk_s;
    logic          vsync_r, href_r, fim_r;
    logic [7:0]    d_r;
    logic [3:0]    db_r;

    assign ilegal_s    = (estado_r > EST_BLANK_H);
    assign habilitar_s = !cam.PWDN && (estado_r != EST_INICIAL) && !ilegal_s;

    ov7670_emulador_gerador_pclk #(.PCLK_DIV(PCLK_DIV)) u_gerador_pclk (
        .clock     (clock),
        .reset     (reset),
        .habilitar (habilitar_s),
        .pclk      (pclk_s),
        .tick      (tick_s)
    );

    // frame sequencing; every duration is counted in PCLK ticks
    always_comb begin
        estado_prox_s = estado_r;
        cont_prox_s   = cont_r;
        linha_prox_s  = linha_r;
        byte_prox_s   = byte_r;
        fim_s         = 1'b0;
        case (estado_r)
            EST_INICIAL: begin
                cont_prox_s   = {TW{1'b0}};
                linha_prox_s  = {LW{1'b0}};
                byte_prox_s   = 8'h00;
                estado_prox_s = iniciar ? EST_VSYNC : EST_INICIAL;
            end
            EST_VSYNC: begin
                linha_prox_s = {LW{1'b0}};
                byte_prox_s  = 8'h00;
                if (tick_s) begin
                    if (cont_r == TW'(VSYNC_LEN - 1)) begin
                        cont_prox_s   = {TW{1'b0}};
                        estado_prox_s = EST_BLANK_V;
                    end else begin
                        cont_prox_s = cont_r + TW'(1);
                    end
                end else begin
                    cont_prox_s = cont_r;
                end
            end
            EST_BLANK_V: begin
                if (tick_s) begin
                    if (cont_r == TW'(BLANK_V - 1)) begin
                        cont_prox_s   = {TW{1'b0}};
                        estado_prox_s = EST_LINHA;
                    end else begin
                        cont_prox_s = cont_r + TW'(1);
                    end
                end else begin
                    cont_prox_s = cont_r;
                end
            end
            EST_LINHA: begin
                if (tick_s) begin
                    byte_prox_s = byte_r + 8'd1;
                    if (cont_r == TW'(COLUNAS - 1)) begin
                        cont_prox_s   = {TW{1'b0}};
                        estado_prox_s = EST_BLANK_H;
                    end else begin
                        cont_prox_s = cont_r + TW'(1);
                    end
                end else begin
                    byte_prox_s = byte_r;
                end
            end
            EST_BLANK_H: begin
                if (tick_s && (cont_r == TW'(BLANK_H - 1))) begin
                    cont_prox_s = {TW{1'b0}};
                    if (linha_r == LW'(LINHAS - 1)) begin
                        fim_s         = 1'b1;
                        estado_prox_s = continuo ? EST_VSYNC : EST_INICIAL;
                    end else begin
                        linha_prox_s  = linha_r + LW'(1);
                        estado_prox_s = EST_LINHA;
                    end
                end else if (tick_s) begin
                    cont_prox_s = cont_r + TW'(1);
                end else begin
                    cont_prox_s = cont_r;
                end
            end
            default: begin
                estado_prox_s = EST_INICIAL;
                cont_prox_s   = {TW{1'b0}};
                linha_prox_s  = {LW{1'b0}};
                byte_prox_s   = 8'h00;
            end
        endcase
        // power-down overrides everything, including a pending end of frame
        if (cam.PWDN) begin
            estado_prox_s = EST_INICIAL;
            cont_prox_s   = {TW{1'b0}};
            linha_prox_s  = {LW{1'b0}};
            byte_prox_s   = 8'h00;
            fim_s         = 1'b0;
        end else begin
            fim_s = fim_s;
        end
    end

    // state, counters and outputs, all taken from the next-state values
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_r <= EST_INICIAL;
            cont_r   <= {TW{1'b0}};
            linha_r  <= {LW{1'b0}};
            byte_r   <= 8'h00;
            vsync_r  <= 1'b0;
            href_r   <= 1'b0;
            d_r      <= 8'h00;
            fim_r    <= 1'b0;
            db_r     <= 4'b0000;
        end else begin
            estado_r <= estado_prox_s;
            cont_r   <= cont_prox_s;
            linha_r  <= linha_prox_s;
            byte_r   <= byte_prox_s;
            vsync_r  <= (estado_prox_s == EST_VSYNC);
            href_r   <= (estado_prox_s == EST_LINHA);
            d_r      <= (estado_prox_s == EST_LINHA) ? byte_prox_s : 8'h00;
            fim_r    <= fim_s;
            db_r     <= ilegal_s ? DB_ILEGAL : {1'b0, estado_prox_s};
        end
    end

    assign cam.PCLK  = pclk_s;
    assign cam.VSYNC = vsync_r;
    assign cam.HREF  = href_r;
    assign cam.D     = d_r;
    assign fim_frame = fim_r;
    assign db_estado = db_r;
endmodule

// File: tb/tb_ov7670_emulador.sv
// Bench for ov7670_emulador: directed frames with a capture-side scoreboard that
// checks every byte latched on a PCLK rise while HREF is high.
`timescale 1ns/1ps
module tb_ov7670_emulador;
    import ov7670_emulador_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic       continuo;
    logic       fim_frame;
    logic [3:0] db_estado;

    ov7670_emulador_if cam ();

    ov7670_emulador dut (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
        .continuo  (continuo),
        .cam       (cam),
        .fim_frame (fim_frame),
        .db_estado (db_estado)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0] dado;
        logic [7:0] ender;
    } esperado_t;

    esperado_t  fila[$];
    int         total    = 0;
    int         passou   = 0;
    int         escritas = 0;
    logic [7:0] ultimo_d = 8'h00;

    task automatic verificar(input string nome, input logic [31:0] atual, input logic [31:0] exig);
        total++;
        if (atual === exig) passou++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", nome, atual, exig);
    endtask

    task automatic empurrar_bytes(input int n);
        esperado_t e;
        for (int k = 0; k < n; k++) begin
            e.dado  = 8'(k);
            e.ender = 8'(k);
            fila.push_back(e);
        end
    endtask

    // capture model: latch D on each PCLK rise with HREF high, at line/column address
    initial begin
        logic       pclk_ant;
        logic       href_ant;
        logic [7:0] d_ant;
        int         linha_cap;
        int         col_cap;
        esperado_t  e;
        pclk_ant = 1'b0; href_ant = 1'b0; d_ant = 8'h00; linha_cap = 0; col_cap = 0;
        forever begin
            @(negedge clock);
            if (cam.VSYNC === 1'b1) begin
                linha_cap = 0;
                col_cap   = 0;
            end
            if (cam.PCLK === 1'b1 && pclk_ant === 1'b0 && cam.HREF === 1'b1) begin
                escritas++;
                ultimo_d = cam.D;
                verificar("byte_estavel", {24'd0, cam.D}, {24'd0, d_ant});
                if (fila.size() == 0) begin
                    verificar("escrita_extra", fila.size(), 32'd1);
                end else begin
                    e = fila.pop_front();
                    verificar("byte", {24'd0, cam.D}, {24'd0, e.dado});
                    verificar("endereco", linha_cap * COLUNAS_PADRAO + col_cap, {24'd0, e.ender});
                end
                col_cap++;
            end
            if (href_ant === 1'b1 && cam.HREF === 1'b0) begin
                linha_cap++;
                col_cap = 0;
            end
            pclk_ant = cam.PCLK;
            href_ant = cam.HREF;
            d_ant    = cam.D;
        end
    end

    // runs a fixed number of cycles, recording frame timing relative to the first negedge
    task automatic observar(input int ciclos, input int solta_em,
                            output int c_vs, output int c_vs_ult, output int c_href,
                            output int c_fim, output int n_fim, output int n_vs, output int vs_alto);
        logic vs_ant;
        vs_ant = 1'b0;
        c_vs = -1; c_vs_ult = -1; c_href = -1; c_fim = -1; n_fim = 0; n_vs = 0; vs_alto = 0;
        for (int c = 0; c < ciclos; c++) begin
            @(negedge clock);
            if (c == solta_em) begin
                iniciar  = 1'b0;
                continuo = 1'b0;
            end
            if (cam.VSYNC === 1'b1 && vs_ant === 1'b0) begin
                n_vs++;
                c_vs_ult = c;
                if (c_vs < 0) c_vs = c;
            end
            if (cam.VSYNC === 1'b1 && n_vs == 1) vs_alto++;
            if (cam.HREF === 1'b1 && c_href < 0) c_href = c;
            if (fim_frame === 1'b1) begin
                n_fim++;
                if (c_fim < 0) c_fim = c;
            end
            vs_ant = cam.VSYNC;
        end
    endtask

    task automatic saidas_zeradas(input string pre);
        verificar({pre, "_pclk"},  {31'd0, cam.PCLK},  32'd0);
        verificar({pre, "_vsync"}, {31'd0, cam.VSYNC}, 32'd0);
        verificar({pre, "_href"},  {31'd0, cam.HREF},  32'd0);
        verificar({pre, "_d"},     {24'd0, cam.D},     32'd0);
        verificar({pre, "_fim"},   {31'd0, fim_frame}, 32'd0);
        verificar({pre, "_db"},    {28'd0, db_estado}, 32'd0);
    endtask

    initial begin
        int c_vs, c_vs_ult, c_href, c_fim, n_fim, n_vs, vs_alto;
        reset = 1'b0; iniciar = 1'b0; continuo = 1'b0; cam.PWDN = 1'b0;
        repeat (3) @(negedge clock);
        saidas_zeradas("reset");
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // single frame, iniciar pulse
        empurrar_bytes(32);
        escritas = 0;
        iniciar  = 1'b1;
        observar(230, 0, c_vs, c_vs_ult, c_href, c_fim, n_fim, n_vs, vs_alto);
        verificar("f1_vsync_inicio", c_vs, 32'd0);
        verificar("f1_vsync_largura", vs_alto, 32'd12);
        verificar("f1_href_atraso", c_href - c_vs, 32'd20);
        verificar("f1_fim_atraso", c_fim - c_vs, 32'd212);
        verificar("f1_fim_pulsos", n_fim, 32'd1);
        verificar("f1_vsync_subidas", n_vs, 32'd1);
        verificar("f1_escritas", escritas, 32'd32);
        verificar("f1_ultimo_byte", {24'd0, ultimo_d}, 32'h1F);
        verificar("f1_fila", fila.size(), 32'd0);
        verificar("f1_db_final", {28'd0, db_estado}, 32'd0);

        // continuous mode, iniciar held high; both released mid second frame
        empurrar_bytes(32);
        empurrar_bytes(32);
        escritas = 0;
        iniciar  = 1'b1;
        continuo = 1'b1;
        observar(440, 300, c_vs, c_vs_ult, c_href, c_fim, n_fim, n_vs, vs_alto);
        verificar("cont_fim1", c_fim - c_vs, 32'd212);
        verificar("cont_vsync2", c_vs_ult, c_fim);
        verificar("cont_fim_pulsos", n_fim, 32'd2);
        verificar("cont_vsync_subidas", n_vs, 32'd2);
        verificar("cont_vsync_largura", vs_alto, 32'd12);
        verificar("cont_escritas", escritas, 32'd64);
        verificar("cont_fila", fila.size(), 32'd0);
        verificar("cont_db_final", {28'd0, db_estado}, 32'd0);

        // power-down right after the 3rd byte of line 2 is latched
        empurrar_bytes(19);
        escritas = 0;
        iniciar  = 1'b1;
        n_fim    = 0;
        for (int c = 0; c < 128; c++) begin
            @(negedge clock);
            if (c == 0) iniciar = 1'b0;
            if (fim_frame === 1'b1) n_fim++;
            if (c == 127) cam.PWDN = 1'b1;
        end
        @(negedge clock);
        saidas_zeradas("pwdn");
        iniciar = 1'b1;
        observar(40, 39, c_vs, c_vs_ult, c_href, c_fim, n_fim, n_vs, vs_alto);
        verificar("pwdn_vsync_ignorado", n_vs, 32'd0);
        verificar("pwdn_fim", n_fim, 32'd0);
        verificar("pwdn_escritas", escritas, 32'd19);
        verificar("pwdn_fila", fila.size(), 32'd0);
        cam.PWDN = 1'b0;
        @(negedge clock);

        // asynchronous reset in the middle of line 0
        empurrar_bytes(3);
        escritas = 0;
        iniciar  = 1'b1;
        for (int c = 0; c < 31; c++) begin
            @(negedge clock);
            if (c == 0) iniciar = 1'b0;
        end
        verificar("pre_rst_href", {31'd0, cam.HREF}, 32'd1);
        #2 reset = 1'b0;
        #1 saidas_zeradas("rst_assinc");
        @(negedge clock);
        reset = 1'b1;
        observar(40, 39, c_vs, c_vs_ult, c_href, c_fim, n_fim, n_vs, vs_alto);
        verificar("rst_sem_retomada", n_vs, 32'd0);
        verificar("rst_db", {28'd0, db_estado}, 32'd0);
        verificar("rst_escritas", escritas, 32'd3);
        verificar("rst_fila", fila.size(), 32'd0);

        $display("%0d/%0d checks passed", passou, total);
        $finish;
    end
endmodule

// File: doc/ov7670_emulador.md
Name: ov7670_emulador

Overview:
- Transmitter end of the OV7670 parallel camera interface.
- Generates the VSYNC, HREF and PCLK timing plus the 8-bit data bus of a synthetic frame with a known byte pattern.
- Drives the existing capture control unit and datapath in FPGA self-test and in simulation, so no physical sensor is needed.
- Frame geometry and blanking are parameterised so the small default frame can be checked exhaustively.

Parameters:
- COLUNAS, 8: active bytes per line (HREF high time, in PCLK periods).
- LINHAS, 4: active lines per frame.
- VSYNC_LEN, 3: VSYNC pulse width, in PCLK periods.
- BLANK_V, 2: PCLK periods between VSYNC falling and the first HREF.
- BLANK_H, 4: PCLK periods with HREF low after each line.
- PCLK_DIV, 2: clock cycles per PCLK half-period (>=1).

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- iniciar  in  1  starts a frame when sampled high in INICIAL; ignored in every other state.
- continuo  in  1  when 1, the next frame starts immediately after the current one ends.
- PWDN  in  1  power-down; while 1, forces INICIAL and holds all sensor outputs low.
- PCLK  out  1  pixel clock.
- VSYNC  out  1  frame sync, active high.
- HREF  out  1  line valid, active high.
- D  out  8  data byte.
- fim_frame  out  1  one-clock pulse at the end of a frame.
- db_estado  out  4  debug state code.

Behaviour:
- Reset (reset=0, asynchronous):
  - state = INICIAL; divider, tick counter, line counter and byte counter = 0.
  - PCLK, VSYNC, HREF, D, fim_frame = 0; db_estado = 0000.
- All outputs are registered.
- Divider `div` counts 0..2*PCLK_DIV-1 and wraps.
  - PCLK = 0 for div < PCLK_DIV, else 1.
  - tick = the cycle in which div wraps to 0. This is the PCLK falling edge.
  - In INICIAL the divider is held at 0 and PCLK = 0.
  - Leaving INICIAL restarts the divider at 0.
- VSYNC, HREF and D change only on a tick, so they are stable PCLK_DIV cycles before each PCLK rising edge.
- State machine (all durations counted in ticks):
  - INICIAL (0000): outputs low. iniciar=1 and PWDN=0 -> VSYNC_PULSO on the next clock.
  - VSYNC_PULSO (0001): VSYNC=1 for VSYNC_LEN ticks; byte counter cleared to 0 -> BLANK_V.
  - BLANK_V (0010): all low for BLANK_V ticks -> LINHA_ATIVA.
  - LINHA_ATIVA (0011): HREF=1 for COLUNAS ticks; D = byte counter; byte counter +1 after each byte -> BLANK_H.
  - BLANK_H (0100): HREF=0, D=0 for BLANK_H ticks.
    - If lines remain: line counter +1 -> LINHA_ATIVA.
    - If last line: fim_frame=1 for one clock -> VSYNC_PULSO if continuo=1, else INICIAL.
- Byte counter is 8 bits and wraps 255->0.
- The pattern is a frame-linear count: byte k of line l = (l*COLUNAS + k) mod 256.
- D = 0 whenever HREF = 0.
- Frame length = VSYNC_LEN + BLANK_V + LINHAS*(COLUNAS+BLANK_H) ticks. Defaults: 53 ticks = 212 clocks.
- PWDN=1 in any state:
  - next clock: state INICIAL, all outputs 0, counters cleared.
  - no fim_frame pulse.
- continuo sampled only at the end-of-frame decision.
- iniciar and PWDN high together: PWDN wins.
- Reset deasserted mid-frame: restarts in INICIAL; never resumes.
- db_estado = 1110 for any illegal state, which recovers to INICIAL.
- Counter widths via $clog2 of the largest count, minimum 1 bit.

Decomposition:
- Shared header ov7670_defs.vh holds:
  - state encodings and the db_estado codes.
  - the default geometry constants, so the capture side and benches use identical values.
- One natural sub-module: gerador_pclk, containing the divider, PCLK and the tick output, with an enable/clear input.

Test Plan:
- Reset: reset=0 mid-LINHA_ATIVA -> PCLK/VSYNC/HREF/D/fim_frame = 0 immediately (asynchronous); db_estado=0000; iniciar required to restart.
- Single frame, defaults, continuo=0, iniciar pulse:
  - VSYNC high for 12 clocks starting one clock after iniciar.
  - HREF first rises 20 clocks after VSYNC rises.
  - Line 0 carries bytes 0x00..0x07, each stable at a PCLK rising edge.
  - fim_frame pulses once, 212 clocks after VSYNC rose; then INICIAL.
- Pattern: count HREF-high PCLK rising edges -> exactly 32 bytes; line 1 = 0x08..0x0F; last byte 0x1F.
- Continuous mode: continuo=1 -> VSYNC rises on the clock after fim_frame; bytes restart at 0x00; iniciar held high has no effect mid-frame.
- Power-down: PWDN=1 on the 3rd byte of line 2 -> next clock all outputs 0, state INICIAL, no fim_frame; iniciar with PWDN=1 ignored.
- Loopback: emulator drives the existing capture control unit -> exactly 32 write enables, stored bytes 0x00..0x1F at consecutive line/column addresses.
